// File: rtl/mod3_serial_tx.sv
// Transmit end of the mod-3 serial link: shifts a parallel word out MSB-first while tracking
// its residue mod 3, then optionally appends the 2-bit residue as a check field.
module mod3_serial_tx #(
    parameter int WIDTH      = 24,
    parameter bit APPEND_RES = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             dout,
    output logic             dout_valid,
    output logic             dout_last,
    output logic [1:0]       residue,
    output logic             frame_done
);

    localparam int              CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]   LAST_IDX = CW'(WIDTH - 1);
    localparam logic [CW-1:0]   PEN_IDX  = CW'(WIDTH - 2);

    typedef enum logic [1:0] {IDLE, DATA, CHECK} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    cnt;
    logic [1:0]       run_res;
    logic [1:0]       chk;
    logic [1:0]       res_step;
    logic             accept;
    logic             consume;
    logic             data_last;
    logic             frame_end;

    // Appending bit b to a value with residue r gives residue (2r + b) mod 3.
    function automatic logic [1:0] mod3_step(input logic [1:0] r, input logic b);
        logic [2:0] v;
        v = {r, 1'b0} + {2'b00, b};
        case (v)
            3'd0, 3'd3: return 2'd0;
            3'd1, 3'd4: return 2'd1;
            default:    return 2'd2;
        endcase
    endfunction

    // NOTE: every signal of this block is given a default before any branch, so no latch is inferred.
    always_comb begin
        consume   = en && (state != IDLE);
        data_last = (state == DATA) && (cnt == LAST_IDX);
        // dout_last marks the frame's final bit, so it doubles as the last_bit decode.
        frame_end = consume && dout_last;
        din_ready = (state == IDLE) || (dout_last && en);
        accept    = din_valid && din_ready;
        res_step  = mod3_step(run_res, shreg[WIDTH-1]);
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) state_nxt = DATA;
            end
            DATA: begin
                if (consume && data_last) begin
                    if (APPEND_RES)  state_nxt = CHECK;
                    else if (accept) state_nxt = DATA;
                    else             state_nxt = IDLE;
                end
            end
            CHECK: begin
                if (frame_end) state_nxt = accept ? DATA : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg      <= '0;
            cnt        <= '0;
            run_res    <= 2'd0;
            chk        <= 2'd0;
            dout       <= 1'b0;
            dout_valid <= 1'b0;
            dout_last  <= 1'b0;
            residue    <= 2'd0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (frame_end) begin
                frame_done <= 1'b1;
                residue    <= (state == CHECK) ? chk : res_step;
            end

            if (accept) begin
                shreg      <= din;
                cnt        <= '0;
                run_res    <= 2'd0;
                dout       <= din[WIDTH-1];
                dout_valid <= 1'b1;
                dout_last  <= 1'b0;
            end else if (frame_end) begin
                cnt        <= '0;
                run_res    <= 2'd0;
                dout       <= 1'b0;
                dout_valid <= 1'b0;
                dout_last  <= 1'b0;
            end else if (consume) begin
                if (state == DATA) begin
                    run_res <= res_step;
                    shreg   <= shreg << 1;
                    // Only reachable with the check field enabled; otherwise this is frame_end.
                    if (cnt == LAST_IDX) begin
                        chk       <= res_step;
                        cnt       <= '0;
                        dout      <= res_step[1];
                        dout_last <= 1'b0;
                    end else begin
                        cnt       <= cnt + CW'(1);
                        dout      <= shreg[WIDTH-2];
                        dout_last <= !APPEND_RES && (cnt == PEN_IDX);
                    end
                end else begin
                    cnt       <= cnt + CW'(1);
                    dout      <= chk[0];
                    dout_last <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mod3_serial_tx.sv
// Self-checking bench for mod3_serial_tx: directed frames plus random words and enable
// patterns, compared against a bit-queue model built from word % 3.
module tb_mod3_serial_tx;

    localparam int W = 24;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         en;
    logic [W-1:0] din;
    logic         din_valid;

    logic         a_ready, a_dout, a_valid, a_last, a_done;
    logic [1:0]   a_res;
    logic         b_ready, b_dout, b_valid, b_last, b_done;
    logic [1:0]   b_res;

    logic         o_ready, o_dout, o_valid, o_last, o_done;
    logic [1:0]   o_res;
    bit           sel_b = 1'b0;

    int           checks = 0;
    int           errors = 0;
    int           en_k   = 0;
    logic [1:0]   last_res;
    logic [W-1:0] q[$];

    mod3_serial_tx #(.WIDTH(W), .APPEND_RES(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .en(en), .din(din), .din_valid(din_valid),
        .din_ready(a_ready), .dout(a_dout), .dout_valid(a_valid), .dout_last(a_last),
        .residue(a_res), .frame_done(a_done)
    );

    mod3_serial_tx #(.WIDTH(W), .APPEND_RES(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .en(en), .din(din), .din_valid(din_valid),
        .din_ready(b_ready), .dout(b_dout), .dout_valid(b_valid), .dout_last(b_last),
        .residue(b_res), .frame_done(b_done)
    );

    assign o_ready = sel_b ? b_ready : a_ready;
    assign o_dout  = sel_b ? b_dout  : a_dout;
    assign o_valid = sel_b ? b_valid : a_valid;
    assign o_last  = sel_b ? b_last  : a_last;
    assign o_done  = sel_b ? b_done  : a_done;
    assign o_res   = sel_b ? b_res   : a_res;

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // mode 0: en always 1; mode 1: repeating 1,0,0; mode 2: random
    task automatic next_en(input int mode);
        case (mode)
            0:       en = 1'b1;
            1:       en = (en_k % 3 == 0);
            default: en = 1'($urandom_range(0, 1));
        endcase
        en_k++;
    endtask

    task automatic check_idle(input string tag, input logic exp_done);
        check({tag, "_dout_valid"}, 32'(o_valid), 32'd0);
        check({tag, "_dout"},       32'(o_dout),  32'd0);
        check({tag, "_dout_last"},  32'(o_last),  32'd0);
        check({tag, "_frame_done"}, 32'(o_done),  32'(exp_done));
        check({tag, "_residue"},    32'(o_res),   32'(last_res));
        check({tag, "_din_ready"},  32'(o_ready), 32'd1);
    endtask

    // Sends every word in q back to back, checking each cycle against the bit-queue model.
    task automatic send(input int mode);
        int   n;
        int   i;
        int   guard;
        logic exp_bits[$];
        logic [1:0] r;
        logic exp_done;
        n = sel_b ? W : W + 2;
        @(negedge clk);
        check("start_ready", 32'(o_ready), 32'd1);
        din = q[0];
        din_valid = 1'b1;
        next_en(mode);
        @(posedge clk);
        exp_done = 1'b0;
        for (int f = 0; f < q.size(); f++) begin
            exp_bits.delete();
            for (int b = W - 1; b >= 0; b--) exp_bits.push_back(q[f][b]);
            r = 2'(q[f] % 3);
            if (!sel_b) begin
                exp_bits.push_back(r[1]);
                exp_bits.push_back(r[0]);
            end
            i = 0;
            guard = 0;
            while (i < n) begin
                @(negedge clk);
                if (guard == 0) begin
                    if (f + 1 < q.size()) begin
                        din = q[f+1];
                        din_valid = 1'b1;
                    end else begin
                        din = W'($urandom);
                        din_valid = 1'b0;
                    end
                end
                check("dout_valid", 32'(o_valid), 32'd1);
                check("dout",       32'(o_dout),  32'(exp_bits[i]));
                check("dout_last",  32'(o_last),  32'(i == n - 1));
                check("frame_done", 32'(o_done),  32'(exp_done));
                check("residue",    32'(o_res),   32'(last_res));
                exp_done = 1'b0;
                next_en(mode);
                #1;
                check("din_ready", 32'(o_ready), 32'((i == n - 1) && en));
                if (en && i == n - 1) begin
                    exp_done = 1'b1;
                    last_res = r;
                end
                @(posedge clk);
                if (en) i++;
                guard++;
                if (guard > 1000) begin
                    check("frame_timeout", 32'(guard), 32'd0);
                    break;
                end
            end
        end
        @(negedge clk);
        din_valid = 1'b0;
        check_idle("end", exp_done);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        din_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        last_res = 2'd0;
    endtask

    initial begin
        logic [W-1:0] w;
        rst_n = 1'b0;
        en = 1'b0;
        din = '0;
        din_valid = 1'b0;
        last_res = 2'd0;
        #12;
        check_idle("reset", 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed frames with the check field appended.
        q.delete(); q.push_back(24'hA59549); send(0);
        q.delete(); q.push_back(24'h000005); send(0);
        q.delete(); q.push_back(24'h000001); send(0);
        q.delete(); q.push_back(24'hFFFFFF); q.push_back(24'h000002); send(0);
        en_k = 0;
        q.delete(); q.push_back(24'hA59549); send(1);

        // Random words, random chain lengths, random enables.
        repeat (6) begin
            q.delete();
            repeat ($urandom_range(1, 3)) q.push_back(W'($urandom));
            send(2);
        end

        // Abort mid-frame with reset.
        w = 24'h3C5A96;
        @(negedge clk);
        din = w;
        din_valid = 1'b1;
        en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        din_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("abort_bit10", 32'(o_dout), 32'(w[W-11]));
        #2 rst_n = 1'b0;
        #1;
        last_res = 2'd0;
        check_idle("abort_async", 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_idle("abort_release", 1'b0);
        q.delete(); q.push_back(24'h00F00D); send(0);

        // Data-only variant.
        do_reset();
        sel_b = 1'b1;
        q.delete(); q.push_back(24'h000005); send(0);
        q.delete(); q.push_back(W'($urandom)); q.push_back(W'($urandom)); send(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
